// File: rtl/frame_fifo_scanout.sv
// Read-side scanout for the show-ahead frame FIFO: free-running raster timing,
// word-to-pixel serialisation, underflow blanking and frame-boundary resync.
//
// state | meaning
// IDLE  | scanout disabled, no pops, data blanked
// PRIME | enabled, waiting for a frame end with FIFO data ready
// RUN   | popping words and serialising pixels on active cycles
// BLANK | underflow or disable seen, blank until frame end, then resync
module frame_fifo_scanout #(
    parameter int PIX_WIDTH    = 16,
    parameter int PIX_PER_WORD = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_POL     = 0
) (
    input  logic                              rd_clk,
    input  logic                              rd_rst,
    input  logic                              en,
    input  logic [PIX_PER_WORD*PIX_WIDTH-1:0] fifo_rd_data,
    input  logic                              fifo_rd_vld,
    output logic                              fifo_rd_en,
    output logic                              vid_hs,
    output logic                              vid_vs,
    output logic                              vid_de,
    output logic [PIX_WIDTH-1:0]              vid_data,
    output logic                              frame_start,
    output logic                              resync_req,
    output logic                              underflow_sticky,
    input  logic                              underflow_clr
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int PSW      = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic SYNC_INACT = (SYNC_POL == 0);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, BLANK} state_t;

    state_t               state, state_nxt;
    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic [PSW-1:0]       pix_sel;
    logic                 active, hs_i, vs_i, line_end, frame_end, pix_last;
    logic                 underflow;
    logic [PIX_WIDTH-1:0] pix_word, pix_nxt;

    assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));
    assign active    = ({1'b0, h_cnt} < (HW+1)'(H_ACTIVE)) && ({1'b0, v_cnt} < (VW+1)'(V_ACTIVE));
    assign hs_i      = ({1'b0, h_cnt} >= (HW+1)'(HS_START)) && ({1'b0, h_cnt} < (HW+1)'(HS_END));
    assign vs_i      = ({1'b0, v_cnt} >= (VW+1)'(VS_START)) && ({1'b0, v_cnt} < (VW+1)'(VS_END));
    assign pix_last  = (pix_sel == PSW'(PIX_PER_WORD - 1));

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            pix_sel <= '0;
        end else begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            if (line_end)
                pix_sel <= '0;
            else if (active)
                pix_sel <= pix_last ? '0 : pix_sel + PSW'(1);
        end
    end

    always_comb begin
        pix_word = '0;
        for (int i = 0; i < PIX_PER_WORD; i++)
            if (pix_sel == PSW'(i))
                pix_word = fifo_rd_data[i*PIX_WIDTH +: PIX_WIDTH];
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        underflow  = 1'b0;
        pix_nxt    = '0;
        case (state)
            IDLE: begin
                if (en)
                    state_nxt = PRIME;
            end
            PRIME: begin
                if (frame_end) begin
                    if (!en)
                        state_nxt = IDLE;
                    else if (fifo_rd_vld)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                fifo_rd_en = active && pix_last;
                // an underflow outranks a simultaneous disable so the flag is kept
                if (active && !fifo_rd_vld) begin
                    underflow = 1'b1;
                    state_nxt = BLANK;
                end else begin
                    if (active)
                        pix_nxt = pix_word;
                    if (!en)
                        state_nxt = BLANK;
                end
            end
            BLANK: begin
                if (frame_end)
                    state_nxt = en ? PRIME : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state            <= IDLE;
            vid_hs           <= SYNC_INACT;
            vid_vs           <= SYNC_INACT;
            vid_de           <= 1'b0;
            vid_data         <= '0;
            frame_start      <= 1'b0;
            resync_req       <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            state       <= state_nxt;
            vid_hs      <= hs_i ^ SYNC_INACT;
            vid_vs      <= vs_i ^ SYNC_INACT;
            vid_de      <= active;
            vid_data    <= pix_nxt;
            frame_start <= (state == RUN) && (h_cnt == '0) && (v_cnt == '0) && fifo_rd_vld;
            resync_req  <= (state == BLANK) && frame_end;
            if (underflow)
                underflow_sticky <= 1'b1;
            else if (underflow_clr)
                underflow_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_fifo_scanout.sv
// Scoreboard bench for frame_fifo_scanout on a small 14x7 raster with two
// pixels per word; expected outputs come from a raster-position reference model.
module tb_frame_fifo_scanout;
    localparam int PW  = 16;
    localparam int PPW = 2;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_BLANK = 3;

    logic              rd_clk = 1'b0;
    logic              rd_rst = 1'b1;
    logic              en = 1'b0;
    logic              fifo_rd_vld = 1'b0;
    logic              underflow_clr = 1'b0;
    logic [PPW*PW-1:0] fifo_rd_data = '0;
    logic              fifo_rd_en, vid_hs, vid_vs, vid_de;
    logic              frame_start, resync_req, underflow_sticky;
    logic [PW-1:0]     vid_data;

    frame_fifo_scanout #(
        .PIX_WIDTH(PW), .PIX_PER_WORD(PPW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .en(en),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
        .frame_start(frame_start), .resync_req(resync_req),
        .underflow_sticky(underflow_sticky), .underflow_clr(underflow_clr)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [PW-1:0] data;
        logic          fs;
        logic          rs;
        logic          st;
    } vid_t;

    vid_t q_vid[$];
    logic q_pop[$];
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    vid_t mon_r;

    int   m_h, m_v, m_mode, head;
    logic m_sticky;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return {16'(2*k + 2), 16'(2*k + 1)};
    endfunction

    function automatic vid_t rst_rec();
        vid_t r;
        r = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = M_IDLE; m_sticky = 1'b0;
    endtask

    // Called at a falling edge: drives one cycle, records expectations, waits for the next falling edge.
    task automatic cycle(input logic en_i, input logic vld_i, input logic clr_i);
        bit   act, fe, und, run_pix;
        int   psel;
        vid_t r;
        en = en_i;
        fifo_rd_vld = vld_i;
        underflow_clr = clr_i;
        fifo_rd_data = vld_i ? word(head) : $urandom;
        act = (m_h < HA) && (m_v < VA);
        fe = (m_h == HT - 1) && (m_v == VT - 1);
        psel = m_h % PPW;
        und = (m_mode == M_RUN) && act && !vld_i;
        run_pix = (m_mode == M_RUN) && act && vld_i;
        q_pop.push_back((m_mode == M_RUN) && act && (psel == PPW - 1));
        r.hs = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
        r.vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
        r.de = act;
        r.data = run_pix ? 16'(2*head + psel + 1) : 16'h0;
        r.fs = (m_mode == M_RUN) && (m_h == 0) && (m_v == 0) && vld_i;
        r.rs = (m_mode == M_BLANK) && fe;
        if (und) m_sticky = 1'b1;
        else if (clr_i) m_sticky = 1'b0;
        r.st = m_sticky;
        q_vid.push_back(r);
        if (run_pix && psel == PPW - 1) head++;
        case (m_mode)
            M_IDLE:  if (en_i) m_mode = M_PRIME;
            M_PRIME: if (fe) begin
                         if (!en_i) m_mode = M_IDLE;
                         else if (vld_i) m_mode = M_RUN;
                     end
            M_RUN:   if (und || !en_i) m_mode = M_BLANK;
            M_BLANK: if (fe) m_mode = en_i ? M_PRIME : M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        m_h = (m_h + 1) % HT;
        if (m_h == 0) m_v = (m_v + 1) % VT;
        @(negedge rd_clk);
    endtask

    // One frame window with fifo_rd_vld dropped for the single cycle at line 2, pixel 4.
    task automatic drop_window(input logic clr_on_drop);
        bit hit;
        for (int i = 0; i < FRAME; i++) begin
            hit = (m_v == 2) && (m_h == 4);
            cycle(1'b1, !hit, hit && clr_on_drop);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'(0));
        check({tag, "_vid_hs"}, 32'(vid_hs), 32'(1));
        check({tag, "_vid_vs"}, 32'(vid_vs), 32'(1));
        check({tag, "_vid_de"}, 32'(vid_de), 32'(0));
        check({tag, "_vid_data"}, 32'(vid_data), 32'(0));
        check({tag, "_frame_start"}, 32'(frame_start), 32'(0));
        check({tag, "_resync_req"}, 32'(resync_req), 32'(0));
        check({tag, "_sticky"}, 32'(underflow_sticky), 32'(0));
    endtask

    initial begin
        forever begin
            @(negedge rd_clk);
            #1;
            if (mon_en) begin
                if (q_pop.size() > 0)
                    check("fifo_rd_en", 32'(fifo_rd_en), 32'(q_pop.pop_front()));
                if (q_vid.size() > 0) begin
                    mon_r = q_vid.pop_front();
                    check("vid_hs", 32'(vid_hs), 32'(mon_r.hs));
                    check("vid_vs", 32'(vid_vs), 32'(mon_r.vs));
                    check("vid_de", 32'(vid_de), 32'(mon_r.de));
                    check("vid_data", 32'(vid_data), 32'(mon_r.data));
                    check("frame_start", 32'(frame_start), 32'(mon_r.fs));
                    check("resync_req", 32'(resync_req), 32'(mon_r.rs));
                    check("underflow_sticky", 32'(underflow_sticky), 32'(mon_r.st));
                end
            end
        end
    end

    initial begin
        bit en_r, vld_r, clr_r;
        model_reset();
        head = 0;
        repeat (3) @(negedge rd_clk);
        #1 check_reset_outputs("reset");
        @(negedge rd_clk);
        rd_rst = 1'b0;
        q_vid.push_back(rst_rec());
        mon_en = 1'b1;

        // disabled: raster timing only
        repeat (FRAME + 5) cycle(1'b0, 1'b1, 1'b0);
        // enable with FIFO always valid
        repeat (3 * FRAME) cycle(1'b1, 1'b1, 1'b0);
        // underflow at line 2 pixel 4, then recovery
        drop_window(1'b0);
        repeat (2 * FRAME) cycle(1'b1, 1'b1, 1'b0);
        // FIFO empty across frame ends: stay primed
        repeat (2 * FRAME) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (2 * FRAME) cycle(1'b1, 1'b1, 1'b0);
        // disable mid-line while running
        for (int i = 0; i < FRAME; i++) begin
            if ((m_v == 1) && (m_h == 3)) break;
            cycle(1'b1, 1'b1, 1'b0);
        end
        repeat (2 * FRAME) cycle(1'b0, 1'b1, 1'b0);
        repeat (2 * FRAME) cycle(1'b1, 1'b1, 1'b0);
        // clear coinciding with underflow, then a clear on its own
        drop_window(1'b1);
        repeat (20) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (2 * FRAME) cycle(1'b1, 1'b1, 1'b0);
        // randomized traffic
        en_r = 1'b1;
        repeat (15 * FRAME) begin
            if ($urandom_range(0, 299) == 0) en_r = ~en_r;
            vld_r = ($urandom_range(0, 99) < 97);
            clr_r = ($urandom_range(0, 99) < 3);
            cycle(en_r, vld_r, clr_r);
        end
        // asynchronous reset in the middle of operation
        #2 rd_rst = 1'b1;
        mon_en = 1'b0;
        #1 check_reset_outputs("mid_reset");
        q_vid.delete();
        q_pop.delete();
        model_reset();
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b0;
        q_vid.push_back(rst_rec());
        mon_en = 1'b1;
        repeat (3 * FRAME) cycle(1'b1, 1'b1, 1'b0);
        @(negedge rd_clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
